referee_m: RTL and testbench
============================

Name: referee_m

Overview:
- Reader end of the board-state interface: consumes the board's refresh strobe and board state, and judges the position.
- On each refresh it snapshots the board and scans it sequentially: 9 cells, 8 win lines.
- It reports result code, winning line, next player to move, and piece counts, with a one-cycle valid strobe.
- It sits beside output_m on refresh_wire/board_state_wire in main, and later gates tester or player move submission.

Parameters:
- NCELLS, 9, number of board cells (fixed; not for override).
- NLINES, 8, number of win lines.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- refresh  input  1  board-updated strobe (`FLAG_T), sampled each clk.
- board_state  input  18  flattened board; cell i at bits [2i+1:2i], row-major, index 0 top-left.
- busy  output  1  high while a snapshot is being scanned.
- result_valid  output  1  one-cycle strobe; result fields are updated this cycle.
- result  output  3  000 in progress, 001 X wins, 010 O wins, 011 draw, 100 illegal.
- win_line  output  4  index of the lowest-numbered winning line; 4'hF if none.
- turn  output  2  next mover (`STATE_T): 01 X, 10 O, 00 when game over or illegal.
- x_count  output  4  number of X cells in the last judged snapshot.
- o_count  output  4  number of O cells in the last judged snapshot.

Behaviour:
- Cell encoding (`STATE_T): 00 empty, 01 X, 10 O, 11 corrupt.
- Win lines:
  - 0-2: rows {0,1,2}, {3,4,5}, {6,7,8}.
  - 3-5: columns {0,3,6}, {1,4,7}, {2,5,8}.
  - 6: diagonal {0,4,8}.
  - 7: anti-diagonal {2,4,6}.
- Reset values: busy 0, result_valid 0, result 000, win_line F, turn 01, x_count 0, o_count 0. Internal: state IDLE, pending 0, accumulators cleared.
- FSM states: IDLE, SCAN, REPORT.
- IDLE: if refresh=1 at an edge, latch board_state into snap, clear accumulators, set idx=0, go to SCAN. busy=1 from the next cycle.
- SCAN, idx 0..8, one per cycle:
  - Count cell idx into x_acc/o_acc.
  - If cell idx is 11, set corrupt.
  - If idx<8, test line idx on snap. An all-01 line sets xwin, an all-10 line sets owin.
  - The first winning line found is captured into line_acc.
  - After idx=8, go to REPORT.
- REPORT, one cycle: result_valid=1 and all result fields registered. Priority:
  1. Illegal if: corrupt; o>x; x>o+1; xwin and owin; xwin with x!=o+1; or owin with x!=o.
  2. Otherwise X win, O win, draw (x+o=9), else in progress.
  3. turn is 01 if x==o, 10 if x==o+1, and 00 for any terminal or illegal result.
  4. x_count/o_count are always reported; win_line is F unless result is 001 or 010.
- Latency: refresh sampled at edge E0, then SCAN occupies 9 cycles, then result_valid is high in the 10th cycle after E0. Outputs hold until the next REPORT; result_valid is low otherwise.
- Refresh while busy (SCAN or REPORT): set pending. Multiple refreshes collapse into one.
- Leaving REPORT with pending=1: clear pending, re-latch the current board_state, and go directly to SCAN. No IDLE cycle.
- Refresh coincident with leaving REPORT counts as pending, so exactly one rescan occurs.
- Reset mid-SCAN or REPORT: aborts immediately, with no result_valid. All outputs return to reset values and pending is cleared.
- Counts are 4-bit; the maximum of 9 cannot overflow.
- board_state changing during SCAN has no effect; only snap is used.

Decomposition:
- Add to defines.v:
  - `RESULT_T [2:0] and result code macros RES_PLAY, RES_XWIN, RES_OWIN, RES_DRAW, RES_ILLEGAL.
  - `LINE_T [3:0] and LINE_NONE 4'hF.
  - Cell macros CELL_EMPTY, CELL_X, CELL_O.
  - `COUNT_T [3:0].
  - `BOARD_FLAT_T [17:0].
- One sub-module, win_line_rom: combinational; maps a 3-bit line index to three 4-bit cell indices, per the table above.
- FSM, accumulators and judgment stay in referee_m.

Test Plan:
- Reset, then empty board and refresh -> busy for 9 cycles, then result_valid in cycle 10 with result 000, turn 01, counts 0/0, win_line F.
- X at cells 0,1,2 and O at 3,4 -> result 001, win_line 0, turn 00, x 3, o 2.
- O on diagonal 2,4,6 with X at 0,1,3 -> result 010, win_line 7, x 3, o 3.
- Full draw board XOX/XOO/OXX -> result 011, win_line F, turn 00, x 5, o 4.
- Illegal cases, each -> result 100 and turn 00:
  - O count exceeds X (O at 0,1).
  - Cell 5 = 11.
  - X row 0 plus O row 1 with 3/3 counts.
- Refresh twice during SCAN, changing board_state between -> one result for the first snapshot, then an immediate single rescan of the later board. Reset asserted at SCAN idx 4 -> no result_valid, outputs at reset values.

Source files
------------

// File: rtl/referee_m_pkg.sv
// Shared types, constants and the position-judging helper for the referee.
// Cell, result and line encodings match the board-state interface.
package referee_m_pkg;

  localparam int NCELLS = 9;
  localparam int NLINES = 8;

  typedef logic [1:0]  cell_t;
  typedef logic [2:0]  result_t;
  typedef logic [3:0]  line_t;
  typedef logic [3:0]  count_t;
  typedef logic [17:0] board_flat_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_X     = 2'b01;
  localparam cell_t CELL_O     = 2'b10;
  localparam cell_t CELL_BAD   = 2'b11;

  localparam result_t RES_PLAY    = 3'b000;
  localparam result_t RES_XWIN    = 3'b001;
  localparam result_t RES_OWIN    = 3'b010;
  localparam result_t RES_DRAW    = 3'b011;
  localparam result_t RES_ILLEGAL = 3'b100;

  localparam line_t LINE_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  typedef struct packed {
    result_t result;
    line_t   win_line;
    cell_t   turn;
  } verdict_t;

  // Illegal positions take priority over wins; a legal win beats a full-board draw.
  function automatic verdict_t judge(input count_t x, input count_t o,
                                     input logic corrupt, input logic xwin,
                                     input logic owin, input line_t line);
    verdict_t v;
    logic     illegal;
    illegal = corrupt || (o > x) || (x > o + 4'd1) || (xwin && owin) ||
              (xwin && (x != o + 4'd1)) || (owin && (x != o));
    v.result   = RES_PLAY;
    v.win_line = LINE_NONE;
    v.turn     = CELL_EMPTY;
    if (illegal) begin
      v.result = RES_ILLEGAL;
    end else if (xwin) begin
      v.result   = RES_XWIN;
      v.win_line = line;
    end else if (owin) begin
      v.result   = RES_OWIN;
      v.win_line = line;
    end else if (x + o == 4'd9) begin
      v.result = RES_DRAW;
    end else begin
      v.result = RES_PLAY;
      v.turn   = (x == o) ? CELL_X : CELL_O;
    end
    return v;
  endfunction

endpackage

// File: rtl/referee_m_win_line_rom.sv
// Combinational table of the eight winning lines, each as three cell indices.
module win_line_rom
  import referee_m_pkg::*;
(
  input  logic [2:0] line,
  output logic [3:0] cell_a,
  output logic [3:0] cell_b,
  output logic [3:0] cell_c
);

  // Rows, then columns, then the two diagonals.
  always_comb begin
    cell_a = 4'd0;
    cell_b = 4'd0;
    cell_c = 4'd0;
    case (line)
      3'd0: begin cell_a = 4'd0; cell_b = 4'd1; cell_c = 4'd2; end
      3'd1: begin cell_a = 4'd3; cell_b = 4'd4; cell_c = 4'd5; end
      3'd2: begin cell_a = 4'd6; cell_b = 4'd7; cell_c = 4'd8; end
      3'd3: begin cell_a = 4'd0; cell_b = 4'd3; cell_c = 4'd6; end
      3'd4: begin cell_a = 4'd1; cell_b = 4'd4; cell_c = 4'd7; end
      3'd5: begin cell_a = 4'd2; cell_b = 4'd5; cell_c = 4'd8; end
      3'd6: begin cell_a = 4'd0; cell_b = 4'd4; cell_c = 4'd8; end
      3'd7: begin cell_a = 4'd2; cell_b = 4'd4; cell_c = 4'd6; end
      default: begin cell_a = 4'd0; cell_b = 4'd0; cell_c = 4'd0; end
    endcase
  end

endmodule

// File: rtl/referee_m.sv
// Board referee: snapshots the board on refresh, scans one cell and one line
// per cycle, then reports a registered verdict with a one-cycle valid strobe.
module referee_m
  import referee_m_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh,
  input  logic [17:0] board_state,
  output logic        busy,
  output logic        result_valid,
  output logic [2:0]  result,
  output logic [3:0]  win_line,
  output logic [1:0]  turn,
  output logic [3:0]  x_count,
  output logic [3:0]  o_count
);

  state_e      state_r, state_nx_s;
  board_flat_t snap_r;
  logic [3:0]  idx_r;
  count_t      x_acc_r, o_acc_r, x_nx_s, o_nx_s;
  logic        corrupt_r, xwin_r, owin_r, pending_r;
  logic        corrupt_nx_s, xwin_nx_s, owin_nx_s;
  line_t       line_acc_r, line_nx_s;
  logic        start_s, line_x_s, line_o_s;
  cell_t       cell_s, va_s, vb_s, vc_s;
  logic [3:0]  la_s, lb_s, lc_s;
  verdict_t    verdict_s;

  logic        busy_r, result_valid_r;
  result_t     result_r;
  line_t       win_line_r;
  cell_t       turn_r;
  count_t      x_count_r, o_count_r;

  win_line_rom u_rom (
    .line   (idx_r[2:0]),
    .cell_a (la_s),
    .cell_b (lb_s),
    .cell_c (lc_s)
  );

  // Next-state logic; start_s marks every edge that latches a fresh snapshot.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (refresh) begin
          state_nx_s = ST_SCAN;
          start_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (idx_r == 4'd8) begin
          state_nx_s = ST_REPORT;
        end else begin
          state_nx_s = ST_SCAN;
        end
      end
      ST_REPORT: begin
        if (pending_r || refresh) begin
          state_nx_s = ST_SCAN;
          start_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Per-cycle scan step: count the current cell and test the line of the same index.
  always_comb begin
    cell_s       = snap_r[{idx_r, 1'b0} +: 2];
    va_s         = snap_r[{la_s, 1'b0} +: 2];
    vb_s         = snap_r[{lb_s, 1'b0} +: 2];
    vc_s         = snap_r[{lc_s, 1'b0} +: 2];
    x_nx_s       = x_acc_r + ((cell_s == CELL_X) ? 4'd1 : 4'd0);
    o_nx_s       = o_acc_r + ((cell_s == CELL_O) ? 4'd1 : 4'd0);
    corrupt_nx_s = corrupt_r | (cell_s == CELL_BAD);
    line_x_s     = (idx_r < 4'd8) && (va_s == CELL_X) && (vb_s == CELL_X) && (vc_s == CELL_X);
    line_o_s     = (idx_r < 4'd8) && (va_s == CELL_O) && (vb_s == CELL_O) && (vc_s == CELL_O);
    xwin_nx_s    = xwin_r | line_x_s;
    owin_nx_s    = owin_r | line_o_s;
    if ((line_acc_r == LINE_NONE) && (line_x_s || line_o_s)) begin
      line_nx_s = idx_r;
    end else begin
      line_nx_s = line_acc_r;
    end
    verdict_s = judge(x_nx_s, o_nx_s, corrupt_nx_s, xwin_nx_s, owin_nx_s, line_nx_s);
  end

  // State, snapshot, accumulators, pending flag and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      snap_r         <= 18'd0;
      idx_r          <= 4'd0;
      x_acc_r        <= 4'd0;
      o_acc_r        <= 4'd0;
      corrupt_r      <= 1'b0;
      xwin_r         <= 1'b0;
      owin_r         <= 1'b0;
      line_acc_r     <= LINE_NONE;
      pending_r      <= 1'b0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      result_r       <= RES_PLAY;
      win_line_r     <= LINE_NONE;
      turn_r         <= CELL_X;
      x_count_r      <= 4'd0;
      o_count_r      <= 4'd0;
    end else begin
      state_r        <= state_nx_s;
      busy_r         <= (state_nx_s == ST_SCAN);
      result_valid_r <= (state_nx_s == ST_REPORT);
      if (start_s) begin
        snap_r     <= board_state;
        idx_r      <= 4'd0;
        x_acc_r    <= 4'd0;
        o_acc_r    <= 4'd0;
        corrupt_r  <= 1'b0;
        xwin_r     <= 1'b0;
        owin_r     <= 1'b0;
        line_acc_r <= LINE_NONE;
      end else if (state_r == ST_SCAN) begin
        idx_r      <= (idx_r == 4'd8) ? idx_r : idx_r + 4'd1;
        x_acc_r    <= x_nx_s;
        o_acc_r    <= o_nx_s;
        corrupt_r  <= corrupt_nx_s;
        xwin_r     <= xwin_nx_s;
        owin_r     <= owin_nx_s;
        line_acc_r <= line_nx_s;
      end
      // A refresh arriving while busy collapses into one deferred rescan.
      if (start_s) begin
        pending_r <= 1'b0;
      end else if ((state_r != ST_IDLE) && refresh) begin
        pending_r <= 1'b1;
      end
      if ((state_r == ST_SCAN) && (idx_r == 4'd8)) begin
        result_r   <= verdict_s.result;
        win_line_r <= verdict_s.win_line;
        turn_r     <= verdict_s.turn;
        x_count_r  <= x_nx_s;
        o_count_r  <= o_nx_s;
      end
    end
  end

  assign busy         = busy_r;
  assign result_valid = result_valid_r;
  assign result       = result_r;
  assign win_line     = win_line_r;
  assign turn         = turn_r;
  assign x_count      = x_count_r;
  assign o_count      = o_count_r;

endmodule

// File: tb/tb_referee_m.sv
// Directed bench for referee_m: table of board verdicts plus multi-cycle
// sequences for pending rescans and mid-scan reset.
module tb_referee_m;

  localparam logic [1:0] E = 2'b00;
  localparam logic [1:0] X = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] K = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        refresh = 1'b0;
  logic [17:0] board_state = 18'd0;
  logic        busy, result_valid;
  logic [2:0]  result;
  logic [3:0]  win_line, x_count, o_count;
  logic [1:0]  turn;

  int checks = 0;
  int errors = 0;

  referee_m dut (
    .clk          (clk),
    .reset        (reset),
    .refresh      (refresh),
    .board_state  (board_state),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .win_line     (win_line),
    .turn         (turn),
    .x_count      (x_count),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] board;
    logic [2:0]  res;
    logic [3:0]  wl;
    logic [1:0]  trn;
    logic [3:0]  xc;
    logic [3:0]  oc;
  } vec_t;

  function automatic logic [17:0] b9(input logic [1:0] c0, c1, c2, c3, c4,
                                     c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string name, input logic [2:0] res, input logic [3:0] wl,
                            input logic [1:0] trn, input logic [3:0] xc, input logic [3:0] oc);
    chk({name, ".result"},   {29'd0, result},   {29'd0, res});
    chk({name, ".win_line"}, {28'd0, win_line}, {28'd0, wl});
    chk({name, ".turn"},     {30'd0, turn},     {30'd0, trn});
    chk({name, ".x_count"},  {28'd0, x_count},  {28'd0, xc});
    chk({name, ".o_count"},  {28'd0, o_count},  {28'd0, oc});
  endtask

  // Pulse refresh for one edge (E0); returns at the negedge of cycle 1.
  task automatic start_scan(input logic [17:0] b);
    board_state = b;
    refresh     = 1'b1;
    @(negedge clk);
    refresh     = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"empty",     b9(E,E,E,E,E,E,E,E,E), 3'b000, 4'hF, 2'b01, 4'd0, 4'd0};
    vecs[1]  = '{"xrow0",     b9(X,X,X,O,O,E,E,E,E), 3'b001, 4'h0, 2'b00, 4'd3, 4'd2};
    vecs[2]  = '{"oanti",     b9(X,X,O,X,O,E,O,E,E), 3'b010, 4'h7, 2'b00, 4'd3, 4'd3};
    vecs[3]  = '{"draw",      b9(X,O,X,X,O,O,O,X,X), 3'b011, 4'hF, 2'b00, 4'd5, 4'd4};
    vecs[4]  = '{"o_gt_x",    b9(O,O,E,E,E,E,E,E,E), 3'b100, 4'hF, 2'b00, 4'd0, 4'd2};
    vecs[5]  = '{"corrupt5",  b9(E,E,E,E,E,K,E,E,E), 3'b100, 4'hF, 2'b00, 4'd0, 4'd0};
    vecs[6]  = '{"bothwin",   b9(X,X,X,O,O,O,E,E,E), 3'b100, 4'hF, 2'b00, 4'd3, 4'd3};
    vecs[7]  = '{"o_to_move", b9(E,E,E,E,X,E,E,E,E), 3'b000, 4'hF, 2'b10, 4'd1, 4'd0};
    vecs[8]  = '{"x_gt_o1",   b9(X,E,E,E,X,E,E,E,E), 3'b100, 4'hF, 2'b00, 4'd2, 4'd0};
    vecs[9]  = '{"xwin_eq",   b9(X,X,X,O,O,E,E,E,O), 3'b100, 4'hF, 2'b00, 4'd3, 4'd3};
    vecs[10] = '{"xwin_full", b9(X,X,X,X,O,O,X,O,O), 3'b001, 4'h0, 2'b00, 4'd5, 4'd4};
    vecs[11] = '{"ocol2",     b9(X,X,O,E,X,O,E,E,O), 3'b010, 4'h5, 2'b00, 4'd3, 4'd3};

    // Reset values.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.valid", {31'd0, result_valid}, 32'd0);
    chk_fields("rst", 3'b000, 4'hF, 2'b01, 4'd0, 4'd0);

    // Table: busy for cycles 1..9, verdict in cycle 10, strobe gone in cycle 11.
    for (int v = 0; v < 12; v++) begin
      start_scan(vecs[v].board);
      for (int c = 1; c <= 9; c++) begin
        chk({vecs[v].name, ".busy"}, {31'd0, busy}, 32'd1);
        chk({vecs[v].name, ".novalid"}, {31'd0, result_valid}, 32'd0);
        board_state = ~vecs[v].board;
        @(negedge clk);
      end
      chk({vecs[v].name, ".valid"}, {31'd0, result_valid}, 32'd1);
      chk({vecs[v].name, ".busy10"}, {31'd0, busy}, 32'd0);
      chk_fields(vecs[v].name, vecs[v].res, vecs[v].wl, vecs[v].trn, vecs[v].xc, vecs[v].oc);
      @(negedge clk);
      chk({vecs[v].name, ".strobe_end"}, {31'd0, result_valid}, 32'd0);
      chk_fields({vecs[v].name, ".hold"}, vecs[v].res, vecs[v].wl, vecs[v].trn,
                 vecs[v].xc, vecs[v].oc);
    end

    // Two refreshes during SCAN: first snapshot judged, then one rescan of the latest board.
    start_scan(vecs[1].board);
    for (int c = 1; c <= 24; c++) begin
      if (c == 10) begin
        chk("pend.valid1", {31'd0, result_valid}, 32'd1);
        chk_fields("pend.first", 3'b001, 4'h0, 2'b00, 4'd3, 4'd2);
      end else if (c == 20) begin
        chk("pend.valid2", {31'd0, result_valid}, 32'd1);
        chk_fields("pend.second", 3'b011, 4'hF, 2'b00, 4'd5, 4'd4);
      end else begin
        chk("pend.novalid", {31'd0, result_valid}, 32'd0);
        chk("pend.busy", {31'd0, busy}, (c <= 19) ? 32'd1 : 32'd0);
      end
      refresh = (c == 3) || (c == 5);
      if (c == 3) board_state = vecs[7].board;
      if (c == 5) board_state = vecs[3].board;
      @(negedge clk);
    end
    refresh = 1'b0;

    // Refresh coincident with leaving REPORT: exactly one rescan, no idle cycle.
    start_scan(vecs[2].board);
    for (int c = 1; c <= 22; c++) begin
      if (c == 10) begin
        chk("coin.valid1", {31'd0, result_valid}, 32'd1);
        chk_fields("coin.first", 3'b010, 4'h7, 2'b00, 4'd3, 4'd3);
      end else if (c == 20) begin
        chk("coin.valid2", {31'd0, result_valid}, 32'd1);
        chk_fields("coin.second", 3'b100, 4'hF, 2'b00, 4'd0, 4'd2);
      end else begin
        chk("coin.novalid", {31'd0, result_valid}, 32'd0);
        chk("coin.busy", {31'd0, busy}, (c <= 19) ? 32'd1 : 32'd0);
      end
      refresh = (c == 10);
      if (c == 10) board_state = vecs[4].board;
      @(negedge clk);
    end
    refresh = 1'b0;

    // Reset while scanning cell 4: abort, reset values, no strobe afterwards.
    start_scan(vecs[10].board);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.valid", {31'd0, result_valid}, 32'd0);
    chk_fields("abort", 3'b000, 4'hF, 2'b01, 4'd0, 4'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort.quiet", {30'd0, busy, result_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
